// File: rtl/cram_writer.sv
// Purpose: serialises one character-slot update into six CRAM byte writes using the CPU store protocol.
// Latency: accept at cycle 0, byte k SETUP at 2+2k and STROBE at 3+2k, req_done at cycle 14 with no stalls.
// Backpressure: req_ready is high only in IDLE; waits for bus_gnt and, when SYNC_TO_BLANK=1, for vertical blanking.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   v_cnt                   current VGA line, used for blanking detection
//   req_valid/req_ready     update handshake; req_id/active/x/y/sprite captured on acceptance
//   req_done                one-cycle pulse after the sixth byte is strobed
//   bus_req/bus_gnt         CRAM bus arbitration with the CPU
//   cram_abus/dbus/write_n  address, data and active-low write strobe
//   cram_cs                 one-hot slot chip select
module cram_writer #(
  parameter logic [15:0] BASE_ADDR     = 16'h3001,
  parameter int unsigned ENTRY_STRIDE  = 6,
  parameter int unsigned VBP           = 31,
  parameter int unsigned V_ACTIVE      = 480,
  parameter bit          SYNC_TO_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  v_cnt,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_id,
  input  logic [7:0]  req_active,
  input  logic [15:0] req_x,
  input  logic [15:0] req_y,
  input  logic [7:0]  req_sprite,
  output logic        req_done,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] cram_abus,
  output logic [7:0]  cram_dbus,
  output logic        cram_write_n,
  output logic [3:0]  cram_cs
);

  typedef enum logic [1:0] {IDLE, ARB, SETUP, STROBE} state_t;

  localparam int unsigned V_END    = VBP + V_ACTIVE;
  localparam logic [15:0] STRIDE16 = 16'(ENTRY_STRIDE);

  state_t      state, state_nxt;
  logic [2:0]  byte_cnt, byte_cnt_nxt;
  logic [1:0]  id_q;
  logic [7:0]  active_q, sprite_q;
  logic [15:0] x_q, y_q;
  logic        started;
  logic        capture;
  logic        xfer;
  logic        blank, ok, go;
  logic [15:0] slot_base, addr_cur;
  logic [7:0]  data_cur;
  logic [3:0]  cs_dec;
  logic [15:0] abus_q;
  logic [7:0]  dbus_q;

  assign blank = (32'(v_cnt) < VBP) || (32'(v_cnt) >= V_END);
  assign ok    = blank || !SYNC_TO_BLANK;
  // Once the first byte has been set up the entry must finish, so a grant
  // loss after blanking ends still re-arbitrates instead of waiting a frame.
  assign go    = ok || started;

  // 16-bit arithmetic, wraps modulo 2^16.
  assign slot_base = BASE_ADDR + 16'(id_q) * STRIDE16;
  assign addr_cur  = slot_base + {13'b0, byte_cnt};
  assign cs_dec    = 4'b0001 << id_q;

  always_comb begin
    data_cur = sprite_q;
    case (byte_cnt)
      3'd0:    data_cur = active_q;
      3'd1:    data_cur = x_q[7:0];
      3'd2:    data_cur = x_q[15:8];
      3'd3:    data_cur = y_q[7:0];
      3'd4:    data_cur = y_q[15:8];
      default: data_cur = sprite_q;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    capture      = 1'b0;
    req_ready    = 1'b0;
    bus_req      = 1'b0;
    cram_cs      = 4'b0000;
    cram_write_n = 1'b1;
    xfer         = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capture      = 1'b1;
          byte_cnt_nxt = 3'd0;
          state_nxt    = ARB;
        end
      end
      ARB: begin
        bus_req = go;
        if (go && bus_gnt) state_nxt = SETUP;
      end
      SETUP: begin
        bus_req = 1'b1;
        xfer    = 1'b1;
        cram_cs = cs_dec;
        // Grant lost before the strobe: hold byte_cnt and retry this byte.
        state_nxt = bus_gnt ? STROBE : ARB;
      end
      STROBE: begin
        bus_req      = 1'b1;
        xfer         = 1'b1;
        cram_cs      = cs_dec;
        cram_write_n = 1'b0;
        if (byte_cnt == 3'd5) begin
          state_nxt = IDLE;
        end else begin
          byte_cnt_nxt = byte_cnt + 3'd1;
          state_nxt    = bus_gnt ? SETUP : ARB;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data hold their last driven value outside a transfer.
  assign cram_abus = xfer ? addr_cur : abus_q;
  assign cram_dbus = xfer ? data_cur : dbus_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      byte_cnt <= 3'd0;
      id_q     <= 2'd0;
      active_q <= 8'd0;
      x_q      <= 16'd0;
      y_q      <= 16'd0;
      sprite_q <= 8'd0;
      started  <= 1'b0;
      req_done <= 1'b0;
      abus_q   <= 16'd0;
      dbus_q   <= 8'd0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      req_done <= (state == STROBE) && (byte_cnt == 3'd5);
      if (capture) begin
        id_q     <= req_id;
        active_q <= req_active;
        x_q      <= req_x;
        y_q      <= req_y;
        sprite_q <= req_sprite;
        started  <= 1'b0;
      end else if (state == SETUP) begin
        started <= 1'b1;
      end
      if (xfer) begin
        abus_q <= addr_cur;
        dbus_q <= data_cur;
      end
    end
  end

endmodule

// File: tb/tb_cram_writer.sv
module tb_cram_writer;

  logic        clk;
  logic        rst_n;
  logic [9:0]  v_cnt;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_id;
  logic [7:0]  req_active;
  logic [15:0] req_x;
  logic [15:0] req_y;
  logic [7:0]  req_sprite;
  logic        req_done;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] cram_abus;
  logic [7:0]  cram_dbus;
  logic        cram_write_n;
  logic [3:0]  cram_cs;

  cram_writer dut (
    .clk(clk), .rst_n(rst_n), .v_cnt(v_cnt),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .req_active(req_active), .req_x(req_x), .req_y(req_y), .req_sprite(req_sprite),
    .req_done(req_done), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .cram_abus(cram_abus), .cram_dbus(cram_dbus), .cram_write_n(cram_write_n),
    .cram_cs(cram_cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic [3:0]  cs;
  } exp_t;

  typedef struct {
    logic [1:0]  id;
    logic [7:0]  act;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  spr;
    logic [9:0]  vcnt;
    int          exp_lat;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   strobe_cnt = 0;
  int   done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference write sequence for one slot update.
  task automatic push_req(input logic [1:0] id, input logic [7:0] act, input logic [15:0] x,
                          input logic [15:0] y, input logic [7:0] spr);
    logic [7:0] bytes [6];
    exp_t e;
    bytes[0] = act;    bytes[1] = x[7:0]; bytes[2] = x[15:8];
    bytes[3] = y[7:0]; bytes[4] = y[15:8]; bytes[5] = spr;
    for (int k = 0; k < 6; k++) begin
      e.a  = 16'(32'h3001 + 32'(id) * 6 + k);
      e.d  = bytes[k];
      e.cs = 4'b0001 << id;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive(input logic [1:0] id, input logic [7:0] act, input logic [15:0] x,
                       input logic [15:0] y, input logic [7:0] spr);
    req_id = id; req_active = act; req_x = x; req_y = y; req_sprite = spr;
  endtask

  // Waits (at negedges) for req_done; returns cycles waited, capped at budget.
  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!req_done && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Scoreboard: every strobe must match the next expected write.
  always @(negedge clk) begin
    if (rst_n && !cram_write_n) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: addr %h data %h, no write expected", cram_abus, cram_dbus);
      end else begin
        mon_e = exp_q.pop_front();
        chk("strobe_addr", 32'(cram_abus), 32'(mon_e.a));
        chk("strobe_data", 32'(cram_dbus), 32'(mon_e.d));
        chk("strobe_cs",   32'(cram_cs),   32'(mon_e.cs));
      end
    end
    if (rst_n && req_done) done_cnt++;
  end

  vec_t vecs[4];

  initial begin
    int n, s0, d0;
    bit found;

    vecs[0] = '{id: 2'd2, act: 8'h01, x: 16'h0123, y: 16'h0045, spr: 8'h07, vcnt: 10'd5,   exp_lat: 14};
    vecs[1] = '{id: 2'd0, act: 8'hFF, x: 16'hFFFF, y: 16'h0000, spr: 8'h80, vcnt: 10'd30,  exp_lat: 14};
    vecs[2] = '{id: 2'd1, act: 8'h5A, x: 16'h8001, y: 16'h7FFE, spr: 8'h00, vcnt: 10'd511, exp_lat: 14};
    vecs[3] = '{id: 2'd3, act: 8'h00, x: 16'h1234, y: 16'hABCD, spr: 8'hEE, vcnt: 10'd700, exp_lat: 14};

    rst_n = 1'b0; v_cnt = 10'd5; req_valid = 1'b0; bus_gnt = 1'b1;
    drive(2'd0, 8'h00, 16'h0000, 16'h0000, 8'h00);
    #1;
    chk("rst_ready",   32'(req_ready),    32'h1);
    chk("rst_done",    32'(req_done),     32'h0);
    chk("rst_bus_req", 32'(bus_req),      32'h0);
    chk("rst_abus",    32'(cram_abus),    32'h0);
    chk("rst_dbus",    32'(cram_dbus),    32'h0);
    chk("rst_write_n", 32'(cram_write_n), 32'h1);
    chk("rst_cs",      32'(cram_cs),      32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single updates, all inside blanking with the bus granted.
    foreach (vecs[i]) begin
      v_cnt = vecs[i].vcnt;
      drive(vecs[i].id, vecs[i].act, vecs[i].x, vecs[i].y, vecs[i].spr);
      push_req(vecs[i].id, vecs[i].act, vecs[i].x, vecs[i].y, vecs[i].spr);
      s0 = strobe_cnt;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("vec_ready_drop", 32'(req_ready), 32'h0);
      chk("vec_bus_req", 32'(bus_req), 32'h1);
      wait_done(40, n);
      chk("vec_latency", 32'(n + 1), 32'(vecs[i].exp_lat));
      chk("vec_ready_at_done", 32'(req_ready), 32'h1);
      chk("vec_strobes", 32'(strobe_cnt - s0), 32'd6);
      chk("vec_queue_empty", 32'(exp_q.size()), 32'h0);
      @(negedge clk);
      chk("vec_done_one_cycle", 32'(req_done), 32'h0);
      chk("vec_idle_cs", 32'(cram_cs), 32'h0);
    end

    // Blank gating: nothing moves in the visible region, boundaries included.
    v_cnt = 10'd100;
    drive(2'd1, 8'h11, 16'h2233, 16'h4455, 8'h66);
    push_req(2'd1, 8'h11, 16'h2233, 16'h4455, 8'h66);
    s0 = strobe_cnt;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("blank_bus_req_vis", 32'(bus_req), 32'h0);
    chk("blank_no_strobe", 32'(strobe_cnt - s0), 32'h0);
    v_cnt = 10'd31;
    @(negedge clk);
    chk("blank_bus_req_31", 32'(bus_req), 32'h0);
    v_cnt = 10'd510;
    @(negedge clk);
    chk("blank_bus_req_510", 32'(bus_req), 32'h0);
    chk("blank_no_strobe2", 32'(strobe_cnt - s0), 32'h0);
    v_cnt = 10'd511;
    #1;
    chk("blank_bus_req_511", 32'(bus_req), 32'h1);
    n = 0;
    while (strobe_cnt == s0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    // Blanking ends mid-entry: the transfer must still complete.
    v_cnt = 10'd200;
    wait_done(40, n);
    chk("blank_done_seen", 32'(req_done), 32'h1);
    chk("blank_strobes", 32'(strobe_cnt - s0), 32'd6);
    chk("blank_queue_empty", 32'(exp_q.size()), 32'h0);
    @(negedge clk);
    v_cnt = 10'd5;

    // Grant dropped during the byte-3 SETUP of slot 0.
    drive(2'd0, 8'hA5, 16'hBEEF, 16'hCAFE, 8'h3C);
    push_req(2'd0, 8'hA5, 16'hBEEF, 16'hCAFE, 8'h3C);
    s0 = strobe_cnt;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 30) begin
      if (cram_abus == 16'h3004 && cram_write_n && cram_cs == 4'b0001) found = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("gdrop_setup3_found", 32'(found), 32'h1);
    bus_gnt = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("gdrop_no_strobe", 32'(cram_write_n), 32'h1);
    end
    chk("gdrop_cs_off", 32'(cram_cs), 32'h0);
    chk("gdrop_bus_req_held", 32'(bus_req), 32'h1);
    chk("gdrop_strobes_before", 32'(strobe_cnt - s0), 32'd3);
    bus_gnt = 1'b1;
    wait_done(40, n);
    chk("gdrop_done_seen", 32'(req_done), 32'h1);
    chk("gdrop_strobes", 32'(strobe_cnt - s0), 32'd6);
    chk("gdrop_queue_empty", 32'(exp_q.size()), 32'h0);
    @(negedge clk);

    // Back-to-back: slot 3 request held valid while slot 0 runs.
    drive(2'd0, 8'h10, 16'h0020, 16'h0030, 8'h40);
    push_req(2'd0, 8'h10, 16'h0020, 16'h0030, 8'h40);
    push_req(2'd3, 8'h91, 16'h9293, 16'h9495, 8'h96);
    s0 = strobe_cnt;
    req_valid = 1'b1;
    @(negedge clk);
    drive(2'd3, 8'h91, 16'h9293, 16'h9495, 8'h96);
    wait_done(40, n);
    chk("b2b_first_lat", 32'(n + 1), 32'd14);
    chk("b2b_ready_at_done", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_second_accepted", 32'(req_ready), 32'h0);
    wait_done(40, n);
    chk("b2b_second_lat", 32'(n + 1), 32'd14);
    chk("b2b_strobes", 32'(strobe_cnt - s0), 32'd12);
    chk("b2b_queue_empty", 32'(exp_q.size()), 32'h0);
    @(negedge clk);

    // Inputs toggled while busy must not affect the captured update.
    drive(2'd2, 8'hC1, 16'hC2C3, 16'hC4C5, 8'hC6);
    push_req(2'd2, 8'hC1, 16'hC2C3, 16'hC4C5, 8'hC6);
    req_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      drive(2'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), 8'($urandom));
      @(negedge clk);
    end
    req_valid = 1'b0;
    wait_done(40, n);
    chk("busy_done_seen", 32'(req_done), 32'h1);
    chk("busy_queue_empty", 32'(exp_q.size()), 32'h0);
    @(negedge clk);

    // Reset asserted during the byte-2 STROBE of slot 1.
    drive(2'd1, 8'h21, 16'h2223, 16'h2425, 8'h26);
    push_req(2'd1, 8'h21, 16'h2223, 16'h2425, 8'h26);
    d0 = done_cnt;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 30) begin
      if (cram_abus == 16'h3009 && !cram_write_n) found = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("rstmid_strobe2_found", 32'(found), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_write_n", 32'(cram_write_n), 32'h1);
    chk("rstmid_cs",      32'(cram_cs),      32'h0);
    chk("rstmid_bus_req", 32'(bus_req),      32'h0);
    chk("rstmid_ready",   32'(req_ready),    32'h1);
    chk("rstmid_done",    32'(req_done),     32'h0);
    exp_q.delete();
    s0 = strobe_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rstmid_no_done", 32'(done_cnt - d0), 32'h0);
    chk("rstmid_no_strobe", 32'(strobe_cnt - s0), 32'h0);
    chk("rstmid_idle_ready", 32'(req_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
